// File: rtl/ks_correction_sequencer.sv
// Sequencer for the 16-bit fault-tolerant Kogge-Stone correction datapath.
// Define KS_SEQ_FAULT_CNT_EN to build the saturating fault_count register.
module ks_correction_sequencer #(
    parameter int unsigned FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [15:0]            req_a,
    input  logic [15:0]            req_b,
    input  logic                   req_cin,
    input  logic                   req_correct,
    output logic [15:0]            op_a,
    output logic [15:0]            op_b,
    output logic                   op_cin,
    output logic [1:0]             slice_sel,
    output logic                   slice_en,
    output logic                   dp_cin,
    input  logic [3:0]             dp_slice_sum,
    input  logic                   dp_slice_carry,
    input  logic                   dp_fault,
    input  logic [15:0]            dp_raw_sum,
    input  logic                   dp_raw_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_sum,
    output logic                   rsp_cout,
    output logic [3:0]             rsp_fault_mask,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RAW,
        RESP
    } state_t;

    state_t state;
    logic   carry_q;
    logic   raw_wait;

    assign req_ready = (state == IDLE) && !rst;
    assign dp_cin    = (slice_sel == 2'd0) ? op_cin : carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_a           <= '0;
            op_b           <= '0;
            op_cin         <= 1'b0;
            slice_sel      <= '0;
            slice_en       <= 1'b0;
            carry_q        <= 1'b0;
            raw_wait       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_sum        <= '0;
            rsp_cout       <= 1'b0;
            rsp_fault_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_a           <= req_a;
                        op_b           <= req_b;
                        op_cin         <= req_cin;
                        rsp_fault_mask <= '0;
                        slice_sel      <= '0;
                        carry_q        <= 1'b0;
                        if (req_correct) begin
                            state    <= CHECK;
                            slice_en <= 1'b1;
                        end else begin
                            state    <= RAW;
                            raw_wait <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    rsp_sum[{slice_sel, 2'b00} +: 4] <= dp_slice_sum;
                    rsp_fault_mask[slice_sel]        <= dp_fault;
                    carry_q                          <= dp_slice_carry;
                    slice_sel                        <= slice_sel + 2'd1;
                    if (slice_sel == 2'd3) begin
                        rsp_cout  <= dp_slice_carry;
                        slice_en  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RAW: begin
                    // First RAW cycle lets the full carry tree settle on the newly latched operands.
                    if (raw_wait) begin
                        raw_wait <= 1'b0;
                    end else begin
                        rsp_sum        <= dp_raw_sum;
                        rsp_cout       <= dp_raw_cout;
                        rsp_fault_mask <= '0;
                        rsp_valid      <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KS_SEQ_FAULT_CNT_EN
    logic [FAULT_CNT_W-1:0] fault_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_q <= '0;
        end else if ((state == CHECK) && dp_fault && (fault_cnt_q != '1)) begin
            fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
        end
    end

    assign fault_count = fault_cnt_q;
`else
    assign fault_count = '0;
`endif

endmodule

// File: tb/tb_ks_correction_sequencer.sv
// Self-checking bench: behavioural datapath + transaction-level model, per-cycle compare.
module tb_ks_correction_sequencer;
    localparam int unsigned CW     = 3;
    localparam int unsigned CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_cin, req_correct;
    logic [15:0]   req_a, req_b, op_a, op_b;
    logic          op_cin, slice_en, dp_cin;
    logic [1:0]    slice_sel;
    logic [3:0]    dp_slice_sum;
    logic          dp_slice_carry, dp_fault;
    logic [15:0]   dp_raw_sum;
    logic          dp_raw_cout;
    logic          rsp_valid, rsp_ready, rsp_cout;
    logic [15:0]   rsp_sum;
    logic [3:0]    rsp_fault_mask;
    logic [CW-1:0] fault_count;

    logic [3:0]    drv_fmask;
    logic [15:0]   drv_raw;
    logic          drv_rawc;
    logic [4:0]    nib_s;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ks_correction_sequencer #(.FAULT_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_correct(req_correct),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .slice_sel(slice_sel), .slice_en(slice_en), .dp_cin(dp_cin),
        .dp_slice_sum(dp_slice_sum), .dp_slice_carry(dp_slice_carry), .dp_fault(dp_fault),
        .dp_raw_sum(dp_raw_sum), .dp_raw_cout(dp_raw_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_fault_mask(rsp_fault_mask),
        .fault_count(fault_count)
    );

    // Datapath stand-in: voters always recover the true nibble sum; fault flag injected per slice.
    always_comb begin
        nib_s          = {1'b0, op_a[4*slice_sel +: 4]} + {1'b0, op_b[4*slice_sel +: 4]} + {4'b0, dp_cin};
        dp_slice_sum   = nib_s[3:0];
        dp_slice_carry = nib_s[4];
        dp_fault       = drv_fmask[slice_sel];
        dp_raw_sum     = drv_raw;
        dp_raw_cout    = drv_rawc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    bit          busy = 1'b0;
    bit          after_rst = 1'b0;
    int          acc_cyc = 0;
    int          rel;
    int          lat;
    bit          m_corr, m_cin, m_rawc, exp_valid, exp_sen;
    logic [15:0] m_a, m_b, m_raw;
    logic [3:0]  m_fmask;
    int unsigned m_count = 0;
    int unsigned full, lowm, cin_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("req_ready_in_rst", 32'(req_ready), 32'd0);
                busy      = 1'b0;
                m_count   = 0;
                after_rst = 1'b1;
            end else begin
                if (after_rst) begin
                    chk("rst_ops", {op_a, op_b}, 32'd0);
                    chk("rst_rsp", 32'({rsp_sum, rsp_cout, rsp_fault_mask, rsp_valid}), 32'd0);
                    chk("rst_ctl", 32'({op_cin, slice_sel, slice_en, dp_cin}), 32'd0);
                    after_rst = 1'b0;
                end
                rel       = cyc - acc_cyc;
                lat       = m_corr ? 4 : 2;
                exp_valid = busy && (rel >= lat);
                exp_sen   = busy && m_corr && (rel < 4);
                chk("req_ready", 32'(req_ready), 32'(!busy));
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                chk("slice_en", 32'(slice_en), 32'(exp_sen));
                chk("fault_count", 32'(fault_count), m_count);
                if (busy) begin
                    chk("op_ab", {op_a, op_b}, {m_a, m_b});
                    chk("op_cin", 32'(op_cin), 32'(m_cin));
                end
                if (exp_sen) begin
                    chk("slice_sel", 32'(slice_sel), 32'(rel));
                    lowm    = (32'd1 << (4 * rel)) - 1;
                    cin_exp = (((m_a & lowm) + (m_b & lowm) + m_cin) >> (4 * rel)) & 1;
                    if (rel == 0) cin_exp = m_cin;
                    chk("dp_cin", 32'(dp_cin), cin_exp);
`ifdef KS_SEQ_FAULT_CNT_EN
                    if (m_fmask[rel] && m_count < CNTMAX) m_count++;
`endif
                end
                if (exp_valid) begin
                    full = 32'(m_a) + 32'(m_b) + 32'(m_cin);
                    chk("rsp_sum", 32'(rsp_sum), m_corr ? (full & 32'hFFFF) : 32'(m_raw));
                    chk("rsp_cout", 32'(rsp_cout), m_corr ? ((full >> 16) & 1) : 32'(m_rawc));
                    chk("rsp_mask", 32'(rsp_fault_mask), m_corr ? 32'(m_fmask) : 32'd0);
                end
                if (exp_valid && rsp_ready) begin
                    busy = 1'b0;
                end else if (!busy && req_valid) begin
                    busy    = 1'b1;
                    acc_cyc = cyc + 1;
                    m_a     = req_a;
                    m_b     = req_b;
                    m_cin   = req_cin;
                    m_corr  = req_correct;
                    m_fmask = drv_fmask;
                    m_raw   = drv_raw;
                    m_rawc  = drv_rawc;
                end
            end
        end
    end

    // Issue one request and complete it; returns the first response seen.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic corr, input logic [3:0] fmask, input logic [15:0] raw,
                           input logic rawc, input int delay, input bit hold,
                           output logic [15:0] sum, output logic cout, output logic [3:0] mask);
        int n;
        sum = '0; cout = 1'b0; mask = '0;
        req_a = a; req_b = b; req_cin = cin; req_correct = corr;
        drv_fmask = fmask; drv_raw = raw; drv_rawc = rawc;
        req_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 32'(n), 32'd0);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        if (hold) begin
            req_a = 16'($urandom); req_b = 16'($urandom); req_cin = 1'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
            if (n > 12) break;
        end
        chk("latency", 32'(n), corr ? 32'd4 : 32'd2);
        sum = rsp_sum; cout = rsp_cout; mask = rsp_fault_mask;
        repeat (delay) @(posedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [15:0] s;
    logic        c;
    logic [3:0]  m;

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cin = 1'b0; req_correct = 1'b0;
        drv_fmask = '0; drv_raw = '0; drv_rawc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_txn(16'h1111, 16'h1010, 1'b0, 1'b1, 4'h0, 16'h0, 1'b0, 3, 1'b1, s, c, m);
        chk("lit_2121_sum", 32'(s), 32'h2121);
        chk("lit_2121_cout_mask", 32'({c, m}), 32'h0);

        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, 4'h0, 16'h0, 1'b0, 0, 1'b0, s, c, m);
        chk("lit_ffff_sum", 32'(s), 32'h0000);
        chk("lit_ffff_cout", 32'(c), 32'd1);

        run_txn(16'h1234, 16'h4321, 1'b1, 1'b1, 4'b0100, 16'h0, 1'b0, 0, 1'b0, s, c, m);
        chk("lit_mask4", 32'(m), 32'h4);
        chk("lit_sum_5556", 32'(s), 32'h5556);
`ifdef KS_SEQ_FAULT_CNT_EN
        chk("lit_count1", 32'(fault_count), 32'd1);
`else
        chk("lit_count0", 32'(fault_count), 32'd0);
`endif

        run_txn(16'h0F0F, 16'h7777, 1'b1, 1'b0, 4'hF, 16'hBEEF, 1'b1, 1, 1'b1, s, c, m);
        chk("lit_raw_sum", 32'(s), 32'hBEEF);
        chk("lit_raw_cout_mask", 32'({c, m}), 32'h10);

        repeat (3) run_txn(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 4'hF, 16'h0, 1'b0, 0, 1'b0, s, c, m);
`ifdef KS_SEQ_FAULT_CNT_EN
        chk("lit_count_sat", 32'(fault_count), CNTMAX);
`else
        chk("lit_count_off", 32'(fault_count), 32'd0);
`endif

        // Abort a corrected add while slice 2 is under check.
        drv_fmask = 4'h3; req_a = 16'hA5A5; req_b = 16'h5A5B; req_cin = 1'b0; req_correct = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (slice_en && slice_sel == 2'd2) break;
            @(posedge clk); #1;
        end
        chk("abort_at_slice2", 32'({slice_en, slice_sel}), 32'b110);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_rsp", 32'({rsp_valid, fault_count}), 32'd0);

        run_txn(16'h8000, 16'h8000, 1'b1, 1'b1, 4'h0, 16'h0, 1'b0, 0, 1'b0, s, c, m);
        chk("lit_after_abort", 32'({c, s}), 32'h10001);

        for (int t = 0; t < 60; t++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), bit'($urandom), s, c, m);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
